// File: rtl/cotm32_pkg.sv
// Shared definitions for the cotm32 execute stage: RV32M divide opcodes and
// small arithmetic helpers used by the divider.
package cotm32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_t;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider for the EX stage: one restoring radix-2 step per
// cycle, with single-cycle handling of divide-by-zero and signed overflow.
module ex_div_unit
    import cotm32_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_valid,
    input  div_op_t         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    // Handshake: an op is accepted in IDLE when i_valid is high; o_stall holds
    // the upstream stages until the result is presented with o_done, and the
    // result stays on o_result for as long as i_stall is high.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'd31;

    state_t          state;
    state_t          state_nxt;
    logic [5:0]      count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] res;
    logic            is_rem;
    logic            neg_quo;
    logic            neg_rem;

    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            sig_ovf;
    logic            special;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] final_res;

    // Operand decode; only consumed on the IDLE accept cycle.
    always_comb begin
        op_signed   = (i_op == DIV_OP_DIV) || (i_op == DIV_OP_REM);
        op_rem      = (i_op == DIV_OP_REM) || (i_op == DIV_OP_REMU);
        a_neg       = op_signed && i_a[XLEN-1];
        b_neg       = op_signed && i_b[XLEN-1];
        abs_a       = a_neg ? twos_neg(i_a) : i_a;
        abs_b       = b_neg ? twos_neg(i_b) : i_b;
        div_zero    = (i_b == '0);
        sig_ovf     = op_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
        special     = div_zero || sig_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = op_rem ? i_a : 32'hFFFF_FFFF;
        end else if (sig_ovf) begin
            special_res = op_rem ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // The remainder is always below the divisor, so the 33-bit trial
    // subtraction's top bit is a reliable borrow flag.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[XLEN]) begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_step = shifted[XLEN-1:0];
            quo_step = {quo[XLEN-2:0], 1'b0};
        end
        if (is_rem) begin
            final_res = neg_rem ? twos_neg(rem_step) : rem_step;
        end else begin
            final_res = neg_quo ? twos_neg(quo_step) : quo_step;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_valid) state_nxt = special ? ST_DONE : ST_BUSY;
            ST_BUSY: if (count == LAST_STEP) state_nxt = ST_DONE;
            ST_DONE: if (!i_stall) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (i_flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            res     <= '0;
            is_rem  <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (i_flush) begin
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        count   <= '0;
                        quo     <= abs_a;
                        rem     <= '0;
                        divisor <= abs_b;
                        is_rem  <= op_rem;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        res     <= special_res;
                    end
                end
                ST_BUSY: begin
                    quo   <= quo_step;
                    rem   <= rem_step;
                    count <= count + 6'd1;
                    if (count == LAST_STEP) res <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign o_stall  = !i_rst && i_valid && (state != ST_DONE);
    assign o_done   = (state == ST_DONE);
    assign o_result = o_done ? res : '0;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: table of divide vectors plus hand-written
// flush, stall, and reset sequences.
module tb_ex_div_unit;
    import cotm32_pkg::*;

    logic        clk;
    logic        i_rst;
    logic        i_flush;
    logic        i_stall;
    logic        i_valid;
    div_op_t     i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    ex_div_unit dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_stall  (i_stall),
        .i_valid  (i_valid),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_stall  (o_stall),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
    endtask

    // Counts cycles from the accept cycle until o_done; operands are scrambled
    // after the accept cycle since the divider must ignore them.
    task automatic wait_done(input int max_cyc, output int lat, output logic [31:0] res,
                             output int stall_bad, output int res_bad);
        lat       = -1;
        res       = '0;
        stall_bad = 0;
        res_bad   = 0;
        for (int cyc = 0; cyc <= max_cyc; cyc++) begin
            if (cyc > 0) begin
                next_cycle();
                i_a  = $urandom;
                i_b  = $urandom;
                i_op = div_op_t'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (o_done) begin
                lat = cyc;
                res = o_result;
                if (o_stall) stall_bad++;
                break;
            end
            if (!o_stall) stall_bad++;
            if (o_result != 32'd0) res_bad++;
        end
    endtask

    task automatic run_vec(input int idx);
        int          lat;
        logic [31:0] res;
        int          stall_bad;
        int          res_bad;
        start_op(vecs[idx].op, vecs[idx].a, vecs[idx].b);
        wait_done(40, lat, res, stall_bad, res_bad);
        check32($sformatf("vec%0d_latency", idx), lat, vecs[idx].lat);
        check32($sformatf("vec%0d_result", idx), res, vecs[idx].exp);
        check32($sformatf("vec%0d_stall_profile", idx), stall_bad, 0);
        check32($sformatf("vec%0d_result_zero_before_done", idx), res_bad, 0);
        next_cycle();
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        int          stall_bad;
        int          res_bad;
        int          seen;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,        32'd14,         33};
        vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,        32'd2,          33};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  33};
        vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  33};
        vecs[4]  = '{DIV_OP_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF,  1};
        vecs[5]  = '{DIV_OP_REMU, 32'd5,          32'd0,        32'd5,          1};
        vecs[6]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[8]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  33};
        vecs[9]  = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[10] = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[11] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
        vecs[12] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[13] = '{DIV_OP_DIVU, 32'd0,          32'd5,        32'd0,          33};
        vecs[14] = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        33};
        vecs[15] = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 33};
        vecs[16] = '{DIV_OP_DIVU, 32'd9,          32'd3,        32'd3,          33};
        vecs[17] = '{DIV_OP_REMU, 32'd0,          32'd0,        32'd0,          1};
        vecs[18] = '{DIV_OP_DIVU, 32'd1,          32'hFFFF_FFFF, 32'd0,         33};

        // Reset, with i_valid high to show o_stall is suppressed.
        i_rst   = 1'b1;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_valid = 1'b1;
        i_op    = DIV_OP_DIVU;
        i_a     = 32'd100;
        i_b     = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check32("rst_done", o_done, 1'b0);
        check32("rst_result", o_result, 32'd0);
        check32("rst_stall", o_stall, 1'b0);
        next_cycle();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check32("idle_done", o_done, 1'b0);
        check32("idle_result", o_result, 32'd0);
        check32("idle_stall", o_stall, 1'b0);
        next_cycle();

        // Table vectors run back-to-back: each starts the cycle after DONE.
        for (int i = 0; i < 19; i++) begin
            run_vec(i);
        end
        i_valid = 1'b0;
        next_cycle();

        // Flush at cycle 10, then a fresh DIVU 9/3 at cycle 11.
        start_op(DIV_OP_DIVU, 32'd1000, 32'd7);
        seen = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            next_cycle();
            if (cyc == 10) i_flush = 1'b1;
            @(negedge clk);
            if (o_done) seen++;
        end
        check32("flush_no_early_done", seen, 0);
        check32("flush_busy_stall", o_stall, 1'b1);
        next_cycle();
        i_flush = 1'b0;
        start_op(DIV_OP_DIVU, 32'd9, 32'd3);
        wait_done(40, lat, res, stall_bad, res_bad);
        check32("after_flush_latency", lat, 33);
        check32("after_flush_result", res, 32'd3);
        check32("after_flush_stall_profile", stall_bad, 0);
        next_cycle();

        // Flush wins over a simultaneous i_valid, even for a special case.
        start_op(DIV_OP_DIV, 32'd5, 32'd0);
        i_flush = 1'b1;
        next_cycle();
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check32("flush_wins_done", o_done, 1'b0);
        next_cycle();

        // Downstream stall for 4 cycles while DONE.
        start_op(DIV_OP_DIVU, 32'd100, 32'd7);
        wait_done(40, lat, res, stall_bad, res_bad);
        check32("stall_latency", lat, 33);
        check32("stall_result", res, 32'd14);
        i_valid = 1'b0;
        i_stall = 1'b1;
        seen = 0;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 4) i_stall = 1'b0;
            @(negedge clk);
            if (o_done && o_result == 32'd14) seen++;
        end
        check32("stall_hold_cycles", seen, 4);
        next_cycle();
        @(negedge clk);
        check32("stall_release_done", o_done, 1'b0);
        check32("stall_release_result", o_result, 32'd0);
        next_cycle();

        // Reset mid-BUSY abandons the operation.
        start_op(DIV_OP_DIVU, 32'd100, 32'd7);
        repeat (5) next_cycle();
        i_rst = 1'b1;
        @(negedge clk);
        check32("rst_busy_stall", o_stall, 1'b0);
        next_cycle();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_done) seen++;
            next_cycle();
        end
        check32("rst_busy_no_done", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
EX_DIV_UNIT -- requirements
Module: ex_div_unit

Interface
REQ-001 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have i_flush  input  1  EX flush; kills any in-flight division.
REQ-004 SHALL have i_stall  input  1  external stall from downstream (EX/MEM); result must be held while high.
REQ-005 SHALL have i_valid  input  1  valid RV32M divide/remainder op present in EX (ID/EX o_valid qualified by decode).
REQ-006 SHALL have i_op  input  div_op_t (2)  DIV, DIVU, REM, REMU.
REQ-007 SHALL have i_a, i_b  input  32 each  dividend, divisor.
REQ-008 SHALL have o_stall  output  1  request to hold ID/EX and upstream stages.
REQ-009 SHALL have o_done  output  1  o_result valid this cycle.
REQ-010 SHALL have o_result  output  32  quotient or remainder per latched op.

Function
REQ-011 States SHALL be IDLE, BUSY, DONE.
REQ-012 IDLE with i_valid: latch op, |a|, |b|, sign flags; next state BUSY, or DONE when the op is a special case (REQ-016/017).
REQ-013 BUSY: one restoring radix-2 step per cycle (shift remainder/quotient left 1, subtract divisor, keep on non-negative); 6-bit counter; after exactly 32 steps go to DONE.
REQ-014 Latency: i_valid first seen at cycle 0 -> o_done at cycle 33 (normal), cycle 1 (special case).
REQ-015 Signed ops: quotient negated when operand signs differ; remainder takes dividend sign; unsigned ops use raw operands; all arithmetic 32-bit, wrap-around in two's complement.
REQ-016 Divisor zero: quotient = 32'hFFFF_FFFF, remainder = dividend, all four ops.
REQ-017 Signed overflow (a = 32'h8000_0000, b = 32'hFFFF_FFFF, DIV/REM): quotient = 32'h8000_0000, remainder = 0.
REQ-018 o_stall SHALL be combinational: i_valid && state != DONE.
REQ-019 DONE: o_done = 1, o_result stable; stay in DONE while i_stall; leave to IDLE on first cycle with !i_stall.
REQ-020 Back-to-back ops: a new i_valid in the cycle after leaving DONE SHALL start normally from IDLE.
REQ-021 i_a/i_b/i_op changes while BUSY or DONE SHALL be ignored.
REQ-022 i_flush in any state SHALL force IDLE next cycle, o_done = 0; flush wins over simultaneous i_valid.
REQ-023 o_result SHALL be 0 outside DONE.

Reset
REQ-024 i_rst SHALL force state IDLE, counter 0, internal registers 0, o_done 0, o_result 0; o_stall SHALL be 0 during reset.
REQ-025 Reset mid-BUSY SHALL abandon the operation; no o_done SHALL follow.

Structure
REQ-026 div_op_t enum (DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU) SHALL live in cotm32_pkg; the state enum stays local.
REQ-027 Single module, no sub-module; datapath and FSM in one file, 120-400 RTL lines.

Verification
REQ-028 DIVU 100 / 7 -> o_stall high cycles 0-32, o_done at cycle 33, result 14; REMU same -> 2.
REQ-029 DIV -7 / 2 -> 32'hFFFF_FFFD (-3); REM -7 / 2 -> 32'hFFFF_FFFF (-1).
REQ-030 DIV 5 / 0 -> o_done at cycle 1, 32'hFFFF_FFFF; REMU 5 / 0 -> 5.
REQ-031 DIV 32'h8000_0000 / -1 -> 32'h8000_0000 at cycle 1; REM -> 0.
REQ-032 i_flush at cycle 10 of a DIVU -> IDLE at cycle 11, no o_done; new DIVU 9/3 next cycle -> 3 after 33 cycles.
REQ-033 i_stall held 4 cycles during DONE -> o_done and o_result stable 5 cycles, then IDLE.
